// File: rtl/controlador_pkg.sv
// Shared types and defaults for the pattern-detector scheduler.
package controlador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_W       = 8;
  localparam int DEF_DET_LAT = 1;

  // Smallest r with 2**r >= v; usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/controlador_detecta_padrao_rr_arbitro.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbitro
  import controlador_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDW   = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   idx,
  output logic             any
);

  // Explicit wrap so non-power-of-two N_REQ never lands on an unused index.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  logic [IDW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = wrap_add(ptr, k);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/controlador_detecta_padrao.sv
// Shares one serial pattern detector among N_REQ requesters: arbitrate, clear,
// shift the word MSB-first, count matches, return {id, count}.
module controlador_detecta_padrao
  import controlador_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int W       = DEF_W,
  parameter int DET_LAT = DEF_DET_LAT,
  parameter int IDW     = clog2(N_REQ),
  parameter int CW      = clog2(W + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               det_x,
  output logic               det_rst,
  input  logic               det_match,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [CW-1:0]      rsp_count,
  output logic               busy
);

  localparam int             SHIFT_LEN = W + DET_LAT;
  localparam int             SW        = clog2(SHIFT_LEN);
  localparam logic [SW-1:0]  CNT_LAST  = SW'(SHIFT_LEN - 1);
  localparam logic [SW-1:0]  CNT_W     = SW'(W);
  localparam logic [SW-1:0]  CNT_LAT   = SW'(DET_LAT);
  localparam logic [IDW-1:0] ID_LAST   = IDW'(N_REQ - 1);

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, id, g_idx;
  logic [N_REQ-1:0] g_onehot;
  logic             g_any, take;
  logic [W-1:0]     word, sel_word;
  logic [SW-1:0]    cnt;
  logic [CW-1:0]    count;

  rr_arbitro #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (g_onehot),
    .idx   (g_idx),
    .any   (g_any)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (g_idx == IDW'(i)) sel_word = req_data[i*W +: W];
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    det_rst   = 1'b0;
    det_x     = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    take      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        // Gated by reset so no handshake completes in a cycle that reset discards.
        if (reset && g_any) begin
          take      = 1'b1;
          req_ready = g_onehot;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        det_rst   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        det_x = (cnt < CNT_W) ? word[W-1] : 1'b0;
        if (cnt == CNT_LAST) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr   <= '0;
      id    <= '0;
      word  <= '0;
      cnt   <= '0;
      count <= '0;
    end else begin
      if (take) begin
        word <= sel_word;
        id   <= g_idx;
        ptr  <= (g_idx == ID_LAST) ? '0 : g_idx + 1'b1;
      end
      if (state == CLEAR) begin
        cnt   <= '0;
        count <= '0;
      end
      if (state == SHIFT) begin
        cnt  <= cnt + 1'b1;
        // Shifting left keeps the next bit to send in word[W-1].
        word <= {word[W-2:0], 1'b0};
        // The first DET_LAT cycles still show results from before the clear.
        if (det_match && cnt >= CNT_LAT) count <= count + 1'b1;
      end
    end
  end

  assign rsp_id    = id;
  assign rsp_count = count;

endmodule

// File: tb/tb_controlador_detecta_padrao.sv
// Bench for controlador_detecta_padrao: transaction-timeline model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_controlador_detecta_padrao;

  localparam int N_REQ    = 4;
  localparam int W        = 8;
  localparam int DET_LAT  = 1;
  localparam int IDW      = 2;
  localparam int CW       = 4;
  localparam int RESP_AGE = W + DET_LAT + 2;
  localparam int MAXC     = 4096;

  logic               clk = 1'b0;
  logic               reset;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               det_x, det_rst, det_match;
  logic               rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]     rsp_id;
  logic [CW-1:0]      rsp_count;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic auto_drop;

  always #5 clk = ~clk;

  controlador_detecta_padrao #(
    .N_REQ   (N_REQ),
    .W       (W),
    .DET_LAT (DET_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .det_x     (det_x),
    .det_rst   (det_rst),
    .det_match (det_match),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .busy      (busy)
  );

  // Detector stub: match echoes det_x one cycle later, cleared by det_rst.
  always @(posedge clk) begin
    if (!reset || det_rst) det_match <= 1'b0;
    else                   det_match <= det_x;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: m_age = -1 when idle, otherwise cycles elapsed since the grant.
  int             m_age   = -1;
  int             m_ptr   = 0;
  logic [W-1:0]   m_word  = '0;
  logic [IDW-1:0] m_id    = '0;
  bit             m_known = 1'b0;
  int             m_pick;

  function automatic int pick(input logic [N_REQ-1:0] v, input int p);
    for (int k = 0; k < N_REQ; k++)
      if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
    return -1;
  endfunction

  assign m_pick = pick(req_valid, m_ptr);

  always @(posedge clk) begin
    if (!reset) begin
      m_age   <= -1;
      m_ptr   <= 0;
      m_known <= 1'b1;
    end else if (m_age < 0) begin
      if (m_pick >= 0) begin
        m_age  <= 1;
        m_id   <= IDW'(m_pick);
        m_word <= req_data[m_pick*W +: W];
        m_ptr  <= (m_pick + 1) % N_REQ;
      end
    end else if (m_age < RESP_AGE) begin
      m_age <= m_age + 1;
    end else if (rsp_ready) begin
      m_age <= -1;
    end
  end

  logic dx_log [0:MAXC-1];
  logic dr_log [0:MAXC-1];
  int   g_id[$], g_cyc[$], r_id[$], r_cnt[$], r_cyc[$];

  always @(negedge clk) begin
    if (m_known) begin
      check("req_ready", 32'(req_ready),
            (reset && m_age < 0 && m_pick >= 0) ? (32'd1 << m_pick) : 32'd0);
      check("det_rst", 32'(det_rst), 32'(m_age == 1));
      check("det_x", 32'(det_x),
            (m_age >= 2 && m_age < 2 + W) ? 32'(m_word[W-1-(m_age-2)]) : 32'd0);
      check("rsp_valid", 32'(rsp_valid), 32'(m_age == RESP_AGE));
      check("busy", 32'(busy), 32'(m_age >= 1));
      if (m_age == RESP_AGE) begin
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_count", 32'(rsp_count), 32'($countones(m_word)));
      end
    end
    if (cyc < MAXC) begin
      dx_log[cyc] = det_x;
      dr_log[cyc] = det_rst;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        g_id.push_back(i);
        g_cyc.push_back(cyc);
      end
    end
    if (rsp_valid && rsp_ready) begin
      r_id.push_back(int'(rsp_id));
      r_cnt.push_back(int'(rsp_count));
      r_cyc.push_back(cyc);
    end
  end

  task automatic step();
    logic [N_REQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    if (auto_drop) req_valid = req_valid & ~acc;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    auto_drop = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_rsps(input int target, input string name);
    int k;
    k = 0;
    while (r_id.size() < target && k < 200) begin
      step();
      k++;
    end
    check({name, "_rsp_timeout"}, 32'(r_id.size() >= target), 32'd1);
  endtask

  int         gb, rb, t, k;
  logic [7:0] dx;
  int         s2_cnt[4]  = '{1, 2, 3, 8};
  int         s3_ord[4]  = '{1, 3, 1, 3};
  logic [7:0] s5_dat[3]  = '{8'h80, 8'h01, 8'h00};
  int         s5_cnt[3]  = '{1, 1, 0};

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    auto_drop = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs",
          32'({req_ready, det_x, det_rst, rsp_valid, rsp_id, rsp_count, busy}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Scenario 1: single word 8'hB5 on requester 0.
    do_reset();
    gb = g_id.size(); rb = r_id.size();
    req_data[0 +: W] = 8'hB5;
    req_valid = 4'b0001;
    wait_rsps(rb + 1, "s1");
    if (r_id.size() > rb && g_id.size() > gb) begin
      t = g_cyc[gb];
      for (int i = 0; i < 8; i++) dx[7-i] = dx_log[t + 2 + i];
      check("s1_grant_id", 32'(g_id[gb]), 32'd0);
      check("s1_det_x_seq", 32'(dx), 32'hB5);
      check("s1_det_rst", 32'(dr_log[t + 1]), 32'd1);
      check("s1_det_rst_len", 32'(dr_log[t + 2]), 32'd0);
      check("s1_id", 32'(r_id[rb]), 32'd0);
      check("s1_count", 32'(r_cnt[rb]), 32'd5);
      check("s1_latency", 32'(r_cyc[rb] - t), 32'd11);
    end

    // Scenario 2: all four valid at once.
    do_reset();
    gb = g_id.size(); rb = r_id.size();
    req_data = {8'hFF, 8'h07, 8'h03, 8'h01};
    req_valid = 4'b1111;
    wait_rsps(rb + 4, "s2");
    if (r_id.size() >= rb + 4 && g_id.size() >= gb + 4) begin
      for (int i = 0; i < 4; i++) begin
        check("s2_grant_order", 32'(g_id[gb + i]), 32'(i));
        check("s2_id", 32'(r_id[rb + i]), 32'(i));
        check("s2_count", 32'(r_cnt[rb + i]), 32'(s2_cnt[i]));
        check("s2_latency", 32'(r_cyc[rb + i] - g_cyc[gb + i]), 32'd11);
      end
    end

    // Scenario 3: requesters 1 and 3 valid continuously.
    do_reset();
    gb = g_id.size(); rb = r_id.size();
    auto_drop = 1'b0;
    req_data = {8'h0F, 8'hAA, 8'h33, 8'h55};
    req_valid = 4'b1010;
    k = 0;
    while (g_id.size() < gb + 4 && k < 200) begin
      step();
      k++;
    end
    req_valid = '0;
    auto_drop = 1'b1;
    wait_rsps(rb + 4, "s3");
    if (g_id.size() >= gb + 4) begin
      k = 0;
      for (int i = 0; i < 4; i++) begin
        check("s3_grant_order", 32'(g_id[gb + i]), 32'(s3_ord[i]));
        if (g_id[gb + i] == 0) k++;
      end
      check("s3_req0_never", 32'(k), 32'd0);
    end

    // Scenario 4: consumer stalls the response for 5 cycles.
    do_reset();
    gb = g_id.size(); rb = r_id.size();
    req_data[2*W +: W] = 8'h5A;
    req_data[0 +: W]   = 8'hC3;
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    k = 0;
    while (!rsp_valid && k < 50) begin
      step();
      k++;
    end
    check("s4_resp_reached", 32'(rsp_valid), 32'd1);
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s4_hold_valid", 32'(rsp_valid), 32'd1);
      check("s4_hold_id", 32'(rsp_id), 32'd2);
      check("s4_hold_count", 32'(rsp_count), 32'd4);
      check("s4_hold_busy", 32'(busy), 32'd1);
      check("s4_hold_no_grant", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("s4_xfer_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("s4_idle_busy", 32'(busy), 32'd0);
    check("s4_idle_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsps(rb + 2, "s4");
    if (r_id.size() >= rb + 2 && g_id.size() > gb) begin
      check("s4_first_id", 32'(r_id[rb]), 32'd2);
      check("s4_stall_latency", 32'(r_cyc[rb] - g_cyc[gb]), 32'd16);
      check("s4_second_id", 32'(r_id[rb + 1]), 32'd0);
      check("s4_second_count", 32'(r_cnt[rb + 1]), 32'd4);
    end

    // Scenario 5: edge bit positions.
    do_reset();
    for (int j = 0; j < 3; j++) begin
      rb = r_id.size();
      req_data[1*W +: W] = s5_dat[j];
      req_valid[1] = 1'b1;
      wait_rsps(rb + 1, "s5");
      if (r_cnt.size() > rb) check("s5_count", 32'(r_cnt[rb]), 32'(s5_cnt[j]));
    end

    // Scenario 6: reset mid-SHIFT abandons the word and restores priority to 0.
    do_reset();
    gb = g_id.size(); rb = r_id.size();
    req_data[2*W +: W] = 8'hF0;
    req_data[0 +: W]   = 8'h3C;
    req_data[3*W +: W] = 8'h0F;
    req_valid = 4'b0100;
    k = 0;
    while (g_id.size() == gb && k < 50) begin
      step();
      k++;
    end
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = 4'b1001;
    @(negedge clk);
    check("s6_in_shift", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("s6_reset_outputs",
          32'({req_ready, det_x, det_rst, rsp_valid, rsp_id, rsp_count, busy}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_rsps(rb + 2, "s6");
    repeat (5) step();
    check("s6_rsp_total", 32'(r_id.size() - rb), 32'd2);
    check("s6_grant_total", 32'(g_id.size() - gb), 32'd3);
    if (r_id.size() >= rb + 2 && g_id.size() >= gb + 3) begin
      check("s6_first_after_reset", 32'(g_id[gb + 1]), 32'd0);
      check("s6_second_after_reset", 32'(g_id[gb + 2]), 32'd3);
      check("s6_rsp0_id", 32'(r_id[rb]), 32'd0);
      check("s6_rsp0_count", 32'(r_cnt[rb]), 32'd4);
      check("s6_rsp1_id", 32'(r_id[rb + 1]), 32'd3);
      check("s6_rsp1_count", 32'(r_cnt[rb + 1]), 32'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
